pipelined_csa_adder: RTL and testbench

PIPELINED_CSA_ADDER -- requirements
Module: pipelined_csa_adder

---
 rtl/pipelined_csa_adder.sv | 162 ++++++++++++++++
 tb/tb_pipelined_csa_adder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csa_adder.sv
// Pipelined multi-operand adder: a linear chain of 3:2 compressors with a register
// every LevelsPerStage levels, finished by a registered carry-propagate adder.
module pipelined_csa_adder #(
  parameter  int AddendDw       = 16,
  parameter  int AddendNum      = 5,
  parameter  int LevelsPerStage = 2,
  localparam int Level          = AddendNum - 2,
  localparam int OutDw          = AddendDw + $clog2(AddendNum),
  localparam int Latency        = (Level + LevelsPerStage - 1) / LevelsPerStage + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic                               signed_i,
  input  logic [AddendNum-1:0][AddendDw-1:0] addend_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [OutDw-1:0]                   sum_o,
  output logic [OutDw-1:0]                   psum_o,
  output logic [OutDw-1:0]                   carry_o
);

  localparam int CsaStages = Latency - 1;
  localparam int ExtDw     = OutDw - AddendDw;

  logic                 advance;
  logic [OutDw-1:0]     ext      [AddendNum];
  logic [OutDw-1:0]     st_psum  [CsaStages+1];
  logic [OutDw-1:0]     st_carry [CsaStages+1];
  logic [CsaStages:0]   st_valid;

  logic                 out_valid_d, out_valid_q;
  logic [OutDw-1:0]     out_sum_d, out_sum_q;
  logic [OutDw-1:0]     out_psum_d, out_psum_q;
  logic [OutDw-1:0]     out_carry_d, out_carry_q;

  // Single global stall: every stage moves together, so ready_o only sees the output slot.
  assign ready_o = ready_i || !out_valid_q;
  assign advance = ready_o;

  always_comb begin
    for (int i = 0; i < AddendNum; i++) begin
      ext[i] = {{ExtDw{signed_i & addend_i[i][AddendDw-1]}}, addend_i[i]};
    end
  end

  // Addends 0 and 1 enter as the initial psum/carry pair, so level l always eats addend l+2.
  assign st_psum[0]  = ext[0];
  assign st_carry[0] = ext[1];
  assign st_valid[0] = valid_i;

  for (genvar s = 0; s < CsaStages; s++) begin : g_stage
    localparam int Lo   = s * LevelsPerStage;
    localparam int Hi   = (Lo + LevelsPerStage < Level) ? Lo + LevelsPerStage : Level;
    localparam int Nl   = Hi - Lo;
    localparam int Rin  = Level - Lo;
    localparam int Rout = Level - Hi;

    logic [OutDw-1:0] add_in [Rin];
    logic [OutDw-1:0] psum_c, carry_c, psum_n, carry_n;
    logic [OutDw-1:0] psum_d, psum_q, carry_d, carry_q;
    logic             valid_d, valid_q;

    if (s == 0) begin : g_first
      always_comb begin
        for (int i = 0; i < Rin; i++) begin
          add_in[i] = ext[i+2];
        end
      end
    end else begin : g_next
      always_comb begin
        for (int i = 0; i < Rin; i++) begin
          add_in[i] = g_stage[s-1].g_rem.add_q[i];
        end
      end
    end

    always_comb begin
      psum_c  = st_psum[s];
      carry_c = st_carry[s];
      psum_n  = '0;
      carry_n = '0;
      for (int l = 0; l < Nl; l++) begin
        psum_n  = psum_c ^ carry_c ^ add_in[l];
        carry_n = (psum_c & carry_c) | (psum_c & add_in[l]) | (carry_c & add_in[l]);
        psum_c  = psum_n;
        carry_c = carry_n << 1;
      end
      valid_d = valid_q;
      psum_d  = psum_q;
      carry_d = carry_q;
      if (advance) begin
        valid_d = st_valid[s];
        psum_d  = psum_c;
        carry_d = carry_c;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) valid_q <= 1'b0;
      else       valid_q <= valid_d;
    end

    always_ff @(posedge clk_i) begin
      psum_q  <= psum_d;
      carry_q <= carry_d;
    end

    // Addends not yet consumed ride along with their stage.
    if (Rout > 0) begin : g_rem
      logic [OutDw-1:0] add_d [Rout];
      logic [OutDw-1:0] add_q [Rout];

      always_comb begin
        for (int i = 0; i < Rout; i++) begin
          add_d[i] = advance ? add_in[i+Nl] : add_q[i];
        end
      end

      always_ff @(posedge clk_i) begin
        for (int i = 0; i < Rout; i++) begin
          add_q[i] <= add_d[i];
        end
      end
    end

    assign st_psum[s+1]  = psum_q;
    assign st_carry[s+1] = carry_q;
    assign st_valid[s+1] = valid_q;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_psum_d  = out_psum_q;
    out_carry_d = out_carry_q;
    if (advance) begin
      out_valid_d = st_valid[CsaStages];
      out_sum_d   = st_psum[CsaStages] + st_carry[CsaStages];
      out_psum_d  = st_psum[CsaStages];
      out_carry_d = st_carry[CsaStages];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) out_valid_q <= 1'b0;
    else       out_valid_q <= out_valid_d;
  end

  always_ff @(posedge clk_i) begin
    out_sum_q   <= out_sum_d;
    out_psum_q  <= out_psum_d;
    out_carry_q <= out_carry_d;
  end

  assign valid_o = out_valid_q;
  assign sum_o   = out_sum_q;
  assign psum_o  = out_psum_q;
  assign carry_o = out_carry_q;

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Bench for pipelined_csa_adder: directed vector table, streaming/stall/reset sequences,
// and small parameter variants with random operands.
module tb_pipelined_csa_adder;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 vld_in;
  logic                 rdy_out;
  logic                 sgn;
  logic [4:0][15:0]     add;
  logic                 vld_out;
  logic                 rdy_in;
  logic [18:0]          sum;
  logic [18:0]          psum;
  logic [18:0]          carry;

  int total = 0;
  int bad = 0;
  int vars_done = 0;

  always #5 clk = ~clk;

  pipelined_csa_adder u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (vld_in),
    .ready_o  (rdy_out),
    .signed_i (sgn),
    .addend_i (add),
    .valid_o  (vld_out),
    .ready_i  (rdy_in),
    .sum_o    (sum),
    .psum_o   (psum),
    .carry_o  (carry)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] ref_sum(input logic s, input logic [4:0][15:0] a);
    int acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (s) acc += int'($signed(a[i]));
      else   acc += int'(a[i]);
    end
    return 19'(acc);
  endfunction

  task automatic drive(input int seed);
    sgn = seed[0];
    for (int j = 0; j < 5; j++) begin
      add[j] = 16'(seed * 4099 + j * 771 + 1);
    end
  endtask

  // Scoreboard: push on input handshake, pop on output handshake; reset flushes.
  logic [18:0] sb_q[$];
  logic [18:0] sb_exp;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (vld_out && rdy_in) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got result 0x%0h want no result", sum);
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_sum", sum, sb_exp);
          check("sb_redundant", 19'(psum + carry), sb_exp);
        end
      end
      if (vld_in && rdy_out) sb_q.push_back(ref_sum(sgn, add));
    end
  end

  typedef struct {
    logic            sg;
    logic [4:0][15:0] a;
    logic [18:0]     exp;
  } vec_t;

  vec_t vec[9];

  initial begin
    int lat, first, last, nvalid;
    logic [18:0] exp_a, exp_h;

    vec[0] = '{1'b0, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 19'd15};
    vec[1] = '{1'b0, {5{16'hFFFF}}, 19'h4FFFB};
    vec[2] = '{1'b1, {5{16'hFFFF}}, 19'h7FFFB};
    vec[3] = '{1'b0, {5{16'h8000}}, 19'h28000};
    vec[4] = '{1'b1, {5{16'h8000}}, 19'h58000};
    vec[5] = '{1'b1, {5{16'h7FFF}}, 19'h27FFB};
    vec[6] = '{1'b1, {16'h0002, 16'h0001, 16'h0100, 16'hFFF0, 16'h0010}, 19'h00103};
    vec[7] = '{1'b0, {16'h0002, 16'h0001, 16'h0100, 16'hFFF0, 16'h0010}, 19'h10103};
    vec[8] = '{1'b1, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001}, 19'h00000};

    rst = 1'b1; vld_in = 1'b0; sgn = 1'b0; add = '0; rdy_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", vld_out, 0);
    check("reset_ready", rdy_out, 1);
    rst = 1'b0;

    // Directed table, one transaction at a time.
    for (int v = 0; v < 9; v++) begin
      sgn = vec[v].sg; add = vec[v].a; vld_in = 1'b1; lat = 0;
      do begin
        @(posedge clk); #1;
        vld_in = 1'b0;
        lat++;
      end while (!vld_out && lat < 10);
      check($sformatf("vec%0d_latency", v), lat, 3);
      check($sformatf("vec%0d_sum", v), sum, vec[v].exp);
      check($sformatf("vec%0d_redundant", v), 19'(psum + carry), vec[v].exp);
      @(posedge clk); #1;
    end

    // Eight back-to-back transactions.
    first = -1; last = -1; nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        drive(k); vld_in = 1'b1;
      end else begin
        vld_in = 1'b0;
      end
      @(posedge clk); #1;
      if (vld_out) begin
        nvalid++;
        if (first < 0) first = k;
        last = k;
      end
    end
    check("b2b_count", nvalid, 8);
    check("b2b_first", first, 2);
    check("b2b_span", last - first, 7);

    // Full pipeline, downstream stalls 4 cycles.
    for (int k = 0; k < 3; k++) begin
      drive(20 + k); vld_in = 1'b1;
      if (k == 0) exp_a = ref_sum(sgn, add);
      @(posedge clk); #1;
    end
    rdy_in = 1'b0;
    drive(23); vld_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_ready", rdy_out, 0);
      check("stall_valid", vld_out, 1);
      check("stall_sum", sum, exp_a);
      check("stall_redundant", 19'(psum + carry), exp_a);
      @(posedge clk); #1;
    end
    rdy_in = 1'b1;
    @(posedge clk); #1;
    vld_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("stall_drain", sb_q.size(), 0);

    // Reset pulse with three transactions in flight.
    for (int k = 0; k < 3; k++) begin
      drive(40 + k); vld_in = 1'b1;
      @(posedge clk); #1;
    end
    vld_in = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_pulse_valid", vld_out, 0);
    check("rst_pulse_ready", rdy_out, 1);
    drive(50); vld_in = 1'b1; exp_h = ref_sum(sgn, add);
    @(posedge clk); #1;
    vld_in = 1'b0;
    nvalid = 0;
    repeat (8) begin
      if (vld_out) begin
        nvalid++;
        check("rst_new_sum", sum, exp_h);
      end
      @(posedge clk); #1;
    end
    check("rst_emerge_count", nvalid, 1);

    for (int i = 0; i < 3000 && vars_done < 4; i++) @(posedge clk);
    check("variants_finished", vars_done, 4);
    check("final_drain", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Parameter variants: (AddendNum, LevelsPerStage) = (3,1) (8,1) (8,6) (5,1).
  for (genvar g = 0; g < 4; g++) begin : g_var
    localparam int N   = (g == 0) ? 3 : (g == 3) ? 5 : 8;
    localparam int L   = (g == 2) ? 6 : 1;
    localparam int Dw  = 8;
    localparam int Od  = Dw + $clog2(N);
    localparam int Lat = (N - 2 + L - 1) / L + 1;

    logic              v_rst, v_vi, v_ro, v_sg, v_vo;
    logic [N-1:0][Dw-1:0] v_ad;
    logic [Od-1:0]     v_so, v_po, v_co;

    pipelined_csa_adder #(
      .AddendDw       (Dw),
      .AddendNum      (N),
      .LevelsPerStage (L)
    ) u_var (
      .clk_i    (clk),
      .rst_i    (v_rst),
      .valid_i  (v_vi),
      .ready_o  (v_ro),
      .signed_i (v_sg),
      .addend_i (v_ad),
      .valid_o  (v_vo),
      .ready_i  (1'b1),
      .sum_o    (v_so),
      .psum_o   (v_po),
      .carry_o  (v_co)
    );

    initial begin
      int acc, lat;
      logic [Od-1:0] expv;
      v_rst = 1'b1; v_vi = 1'b0; v_sg = 1'b0; v_ad = '0;
      repeat (2) @(posedge clk);
      #1;
      v_rst = 1'b0;
      for (int t = 0; t < 6; t++) begin
        v_sg = t[0];
        acc = 0;
        for (int i = 0; i < N; i++) begin
          if (t >= 4) v_ad[i] = {Dw{1'b1}};
          else        v_ad[i] = Dw'($urandom);
          if (v_sg) acc += int'($signed(v_ad[i]));
          else      acc += int'(v_ad[i]);
        end
        expv = Od'(acc);
        v_vi = 1'b1; lat = 0;
        do begin
          @(posedge clk); #1;
          v_vi = 1'b0;
          lat++;
        end while (!v_vo && lat < 20);
        check($sformatf("var%0d_latency", g), lat, Lat);
        check($sformatf("var%0d_sum", g), v_so, expv);
        check($sformatf("var%0d_redundant", g), Od'(v_po + v_co), expv);
        @(posedge clk); #1;
      end
      vars_done++;
    end
  end

endmodule
